// File: rtl/seven_segment_scanner.sv
// Seven-segment scan controller: one-hot digit code plus digit enable, values committed at frame start (SCANNER_LZ_BLANK_EN adds leading-zero blanking).
// Latency: registered outputs update on the edge ending each tick; a load reaches the display within DIGITS*DIV cycles.
// Backpressure: none; load is taken every cycle and the last load before a commit wins.
module seven_segment_scanner #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] value,
  input  logic                load,
  input  logic                blank,
  output logic [15:0]         onehot,
  output logic [DIGITS-1:0]   digit_en,
  output logic                pending,
  output logic                frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);

  typedef enum logic {
    RESET_DARK,
    SCAN
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0]       pcnt, pcnt_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic [4*DIGITS-1:0] shadow, shadow_nxt;
  logic [4*DIGITS-1:0] active, active_nxt;
  logic                pending_nxt;
  logic                started;
  logic                tick;
  logic                commit;
  logic [DIGITS-1:0]   dsel;
  logic [DIGITS-1:0]   keep;
  logic                keep_sel;
  logic [3:0]          nib;
  logic [15:0]         onehot_nxt;
  logic [DIGITS-1:0]   digit_en_nxt;

  assign started = (state == SCAN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RESET_DARK;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RESET_DARK: if (tick) state_nxt = SCAN;
      SCAN:       state_nxt = SCAN;
      default:    state_nxt = RESET_DARK;
    endcase
  end

  // Prescaler, digit index and the shadow/active double buffer.
  always_comb begin
    tick        = (pcnt == PCNT_LAST);
    commit      = tick && (idx == '0);
    pcnt_nxt    = tick ? '0 : pcnt + PW'(1);
    idx_nxt     = idx;
    shadow_nxt  = shadow;
    active_nxt  = active;
    pending_nxt = pending;
    if (tick) begin
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
    if (commit) begin
      if (load) begin
        active_nxt  = value;
        shadow_nxt  = value;
        pending_nxt = 1'b0;
      end else if (pending) begin
        active_nxt  = shadow;
        pending_nxt = 1'b0;
      end
    end else if (load) begin
      shadow_nxt  = value;
      pending_nxt = 1'b1;
    end
  end

`ifdef SCANNER_LZ_BLANK_EN
  // A digit is kept if it or any digit above it is nonzero; digit 0 always shows.
  always_comb begin
    logic above;
    above = 1'b0;
    keep  = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      above   = above | (|active_nxt[4*d +: 4]) | (d == 0);
      keep[d] = above;
    end
  end
`else
  assign keep = '1;
`endif

  // Nibble comes from active_nxt so a commit tick shows the freshly committed value.
  always_comb begin
    dsel     = '0;
    nib      = '0;
    keep_sel = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (idx == IW'(d)) begin
        dsel[d]  = 1'b1;
        nib      = active_nxt[4*d +: 4];
        keep_sel = keep[d];
      end
    end
  end

  always_comb begin
    onehot_nxt   = onehot;
    digit_en_nxt = digit_en;
    if (blank) begin
      onehot_nxt   = '0;
      digit_en_nxt = '0;
    end else if (tick) begin
      digit_en_nxt = dsel;
      onehot_nxt   = keep_sel ? (16'h0001 << nib) : 16'h0000;
    end else if (!started) begin
      onehot_nxt   = '0;
      digit_en_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt       <= '0;
      idx        <= '0;
      shadow     <= '0;
      active     <= '0;
      pending    <= 1'b0;
      onehot     <= '0;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else begin
      pcnt       <= pcnt_nxt;
      idx        <= idx_nxt;
      shadow     <= shadow_nxt;
      active     <= active_nxt;
      pending    <= pending_nxt;
      onehot     <= onehot_nxt;
      digit_en   <= digit_en_nxt;
      frame_done <= commit;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner (DIGITS=4, DIV=4): cycle-count model checked every cycle plus literal pins.
module tb_seven_segment_scanner;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [4*DIGITS-1:0] value;
  logic                load;
  logic                blank;
  logic [15:0]         onehot;
  logic [DIGITS-1:0]   digit_en;
  logic                pending;
  logic                frame_done;

  seven_segment_scanner #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .blank      (blank),
    .onehot     (onehot),
    .digit_en   (digit_en),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Model: cycles since reset release decide tick and slot directly.
  int                  m_cyc = 0;
  int                  m_slot;
  int                  m_nib;
  int                  m_hi;
  bit                  m_tick;
  bit                  m_commit;
  bit                  model_ok = 1'b0;
  logic [4*DIGITS-1:0] m_active;
  logic [4*DIGITS-1:0] m_shadow;
  logic                m_pend;
  logic [15:0]         m_oh;
  logic [DIGITS-1:0]   m_den;
  logic                m_fd;

  int checks = 0;
  int errors = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cyc    = 0;
      m_active = '0;
      m_shadow = '0;
      m_pend   = 1'b0;
      m_oh     = '0;
      m_den    = '0;
      m_fd     = 1'b0;
      model_ok = 1'b1;
    end else begin
      m_tick   = ((m_cyc % DIV) == DIV - 1);
      m_slot   = (m_cyc / DIV) % DIGITS;
      m_commit = m_tick && (m_slot == 0);
      if (m_commit) begin
        if (load) begin
          m_active = value;
          m_pend   = 1'b0;
        end else if (m_pend) begin
          m_active = m_shadow;
          m_pend   = 1'b0;
        end
      end else if (load) begin
        m_shadow = value;
        m_pend   = 1'b1;
      end
      m_fd = m_commit;
      if (blank) begin
        m_oh  = '0;
        m_den = '0;
      end else if (m_tick) begin
        m_den = DIGITS'(1 << m_slot);
        m_nib = int'((m_active >> (4 * m_slot)) & 16'hF);
        m_hi  = 0;
        for (int d = 0; d < DIGITS; d++) begin
          if (((m_active >> (4 * d)) & 16'hF) != 0) m_hi = d;
        end
`ifdef SCANNER_LZ_BLANK_EN
        m_oh = (m_slot <= m_hi) ? 16'(1 << m_nib) : 16'h0000;
`else
        m_oh = 16'(1 << m_nib);
`endif
      end
      m_cyc++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (model cycle %0d)", nm, act, exp, m_cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (model_ok) begin
      chk("onehot", 32'(onehot), 32'(m_oh));
      chk("digit_en", 32'(digit_en), 32'(m_den));
      chk("pending", 32'(pending), 32'(m_pend));
      chk("frame_done", 32'(frame_done), 32'(m_fd));
    end
  endtask

  // Advance until cycle k is the next one the DUT samples.
  task automatic at(input int k);
    int guard;
    guard = 0;
    while (m_cyc < k && guard < 1000) begin
      step();
      guard++;
    end
    if (m_cyc < k) begin
      checks++;
      errors++;
      $display("FAIL wait_cycle: reached %0d expected %0d", m_cyc, k);
    end
  endtask

  task automatic pin(input string nm, input logic [DIGITS-1:0] den, input logic [15:0] oh);
    chk({nm, "_den"}, 32'(digit_en), 32'(den));
    chk({nm, "_oh"}, 32'(onehot), 32'(oh));
  endtask

  logic [15:0] lz_zero;

  initial begin
`ifdef SCANNER_LZ_BLANK_EN
    lz_zero = 16'h0000;
`else
    lz_zero = 16'h0001;
`endif
    rst_n = 1'b0;
    load  = 1'b0;
    blank = 1'b0;
    value = '0;
    repeat (3) step();
    pin("reset", 4'b0000, 16'h0000);
    chk("reset_pending", 32'(pending), 32'd0);
    chk("reset_fd", 32'(frame_done), 32'd0);

    // First frame of 1A3F
    rst_n = 1'b1;
    load  = 1'b1;
    value = 16'h1A3F;
    at(1);
    load = 1'b0;
    chk("load_pending", 32'(pending), 32'd1);
    at(3);
    pin("pre_tick", 4'b0000, 16'h0000);
    at(4);
    pin("d0_F", 4'b0001, 16'h8000);
    chk("first_fd", 32'(frame_done), 32'd1);
    at(5);
    chk("fd_pulse", 32'(frame_done), 32'd0);
    at(8);
    pin("d1_3", 4'b0010, 16'h0008);
    at(12);
    pin("d2_A", 4'b0100, 16'h0400);
    at(16);
    pin("d3_1", 4'b1000, 16'h0002);

    // Two loads during the digit-2 slot; the last one wins at the next frame
    at(24);
    load  = 1'b1;
    value = 16'h0000;
    at(25);
    load = 1'b0;
    at(26);
    load  = 1'b1;
    value = 16'h5555;
    at(27);
    load = 1'b0;
    at(28);
    pin("old_d2", 4'b0100, 16'h0400);
    chk("shadow_pending", 32'(pending), 32'd1);
    at(35);
    chk("pending_hold", 32'(pending), 32'd1);
    at(36);
    pin("new_d0_5", 4'b0001, 16'h0020);
    chk("commit_pending", 32'(pending), 32'd0);

    // Load coincident with the commit tick
    at(51);
    load  = 1'b1;
    value = 16'h0789;
    at(52);
    load = 1'b0;
    pin("direct_d0_9", 4'b0001, 16'h0200);
    chk("direct_pending", 32'(pending), 32'd0);
    at(56);
    pin("direct_d1_8", 4'b0010, 16'h0100);

    // Blank for 10 cycles, released mid-slot
    at(58);
    blank = 1'b1;
    at(59);
    pin("blank_dark", 4'b0000, 16'h0000);
    at(68);
    blank = 1'b0;
    chk("blank_fd", 32'(frame_done), 32'd1);
    pin("blank_commit_dark", 4'b0000, 16'h0000);
    at(71);
    pin("release_midslot", 4'b0000, 16'h0000);
    at(72);
    pin("release_d1_8", 4'b0010, 16'h0100);

    // One-cycle reset with a load pending
    at(73);
    load  = 1'b1;
    value = 16'h2222;
    at(74);
    load = 1'b0;
    chk("pre_reset_pending", 32'(pending), 32'd1);
    at(75);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    pin("midreset", 4'b0000, 16'h0000);
    chk("midreset_pending", 32'(pending), 32'd0);
    at(3);
    pin("post_reset_dark", 4'b0000, 16'h0000);
    at(4);
    pin("post_reset_d0", 4'b0001, 16'h0001);
    at(8);
    pin("zero_d1", 4'b0010, lz_zero);

    // 0042: upper zeros blank only with leading-zero blanking
    at(10);
    load  = 1'b1;
    value = 16'h0042;
    at(11);
    load = 1'b0;
    at(20);
    pin("v42_d0", 4'b0001, 16'h0004);
    at(24);
    pin("v42_d1", 4'b0010, 16'h0010);
    at(28);
    pin("v42_d2", 4'b0100, lz_zero);
    at(32);
    pin("v42_d3", 4'b1000, lz_zero);
    at(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
